// File: rtl/syn_perf_monitor.sv
// Pipeline event counters with a freeze-at-halt FSM and an 8-digit multiplexed hex display.
// Optional macro PERF_MON_DP_EN lights the decimal point to flag the IDLE/HALT states.
module syn_perf_monitor #(
    parameter int CNT_WIDTH = 32,
    parameter int SCAN_DIV  = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        halted,
    input  logic        jumped,
    input  logic        is_branch,
    input  logic        branched,
    input  logic        bubble,
    input  logic [31:0] display,
    input  logic [31:0] pc_dbg,
    input  logic [2:0]  sel,
    output logic [31:0] value,
    output logic [7:0]  seg_n,
    output logic [7:0]  an_n,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int PW = $clog2(SCAN_DIV);

    state_t               state_q;
    state_t               state_nxt;
    logic                 count_en;
    logic [4:0]           events;
    logic [CNT_WIDTH-1:0] cnt_q [5];
    logic [31:0]          sel_val;
    logic [PW-1:0]        presc_q;
    logic                 scan_tc;
    logic [2:0]           idx_q;
    logic [2:0]           idx_nxt;
    logic [6:0]           seg_q;
    logic                 dp_q;

    function automatic state_t next_state(state_t s, logic c, logic e, logic h);
        if (c) return IDLE;
        case (s)
            RUN:     return (e && h) ? HALT : RUN;
            HALT:    return HALT;
            default: return e ? RUN : IDLE;  // the unused encoding behaves as IDLE
        endcase
    endfunction

    function automatic logic [6:0] hex7(logic [3:0] d);
        case (d)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign state_nxt = next_state(state_q, clr, en, halted);
    assign state     = state_q;

    // HALT never counts; the IDLE->RUN edge itself is a counted cycle.
    assign count_en = en && !halted && (state_q != HALT);
    assign events   = {bubble, branched, is_branch, jumped, 1'b1};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // NOTE: the five counters are plain flops, not a RAM, so resetting the whole array is cheap and intended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (count_en && events[i] && (cnt_q[i] != '1))
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: sel_val gets a default first so no path through the case infers a latch.
    always_comb begin
        sel_val = '0;
        case (sel)
            3'd0: sel_val = display;
            3'd1: sel_val = 32'(cnt_q[0]);
            3'd2: sel_val = 32'(cnt_q[1]);
            3'd3: sel_val = 32'(cnt_q[2]);
            3'd4: sel_val = 32'(cnt_q[3]);
            3'd5: sel_val = 32'(cnt_q[4]);
            3'd6: sel_val = pc_dbg;
            default: sel_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value <= '0;
        else        value <= sel_val;
    end

    assign scan_tc = (presc_q == PW'(SCAN_DIV - 1));
    assign idx_nxt = idx_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_n    <= 8'hFE;
            seg_q   <= 7'h40;
        end else if (scan_tc) begin
            presc_q <= '0;
            idx_q   <= idx_nxt;
            an_n    <= ~(8'd1 << idx_nxt);
            seg_q   <= hex7(value[{idx_nxt, 2'b00} +: 4]);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

`ifdef PERF_MON_DP_EN
    logic [2:0] idx_d;
    assign idx_d = scan_tc ? idx_nxt : idx_q;

    // Built from next-cycle index and state so the dot lines up with an_n and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp_q <= 1'b1;
        else        dp_q <= !(((idx_d == 3'd0) && (state_nxt == HALT)) ||
                              ((idx_d == 3'd1) && (state_nxt == IDLE)));
    end
`else
    assign dp_q = 1'b1;
`endif

    assign seg_n = {dp_q, seg_q};

endmodule

// File: tb/tb_syn_perf_monitor.sv
// Bench for syn_perf_monitor: two instances (32-bit/SCAN_DIV=4 and 4-bit/SCAN_DIV=2) on shared stimulus.
// Directed vector table, display scan sequences, then random stimulus against a behavioural model.
module tb_syn_perf_monitor;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, clr, halted, jumped, is_branch, branched, bubble;
    logic [31:0] display, pc_dbg;
    logic [2:0]  sel;
    logic [31:0] value_a, value_b;
    logic [7:0]  seg_n_a, seg_n_b, an_n_a, an_n_b;
    logic [1:0]  state_a, state_b;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model: true event counts, coarse mode, edges since reset release
    longint unsigned m_cnt [5];
    int              m_mode;
    int              n_edges;
    logic [31:0]     exp_val_a, exp_val_b;

    typedef struct {
        logic       clr, en, halted, jumped, is_branch, branched, bubble;
        logic [2:0] sel;
        int         reps;
        logic [1:0] st;
        logic [31:0] va, vb;
    } vec_t;
    vec_t vq[$];

    logic [6:0] digit_seg [8];

    syn_perf_monitor #(.CNT_WIDTH(32), .SCAN_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .halted(halted), .jumped(jumped),
        .is_branch(is_branch), .branched(branched), .bubble(bubble), .display(display),
        .pc_dbg(pc_dbg), .sel(sel), .value(value_a), .seg_n(seg_n_a), .an_n(an_n_a),
        .state(state_a)
    );

    syn_perf_monitor #(.CNT_WIDTH(4), .SCAN_DIV(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .halted(halted), .jumped(jumped),
        .is_branch(is_branch), .branched(branched), .bubble(bubble), .display(display),
        .pc_dbg(pc_dbg), .sel(sel), .value(value_b), .seg_n(seg_n_b), .an_n(an_n_b),
        .state(state_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_sel(input logic [2:0] s, input bit narrow);
        longint unsigned c;
        case (s)
            3'd0: return display;
            3'd6: return pc_dbg;
            3'd7: return 32'h0;
            default: begin
                c = m_cnt[s - 1];
                if (narrow && c > 15) c = 15;
                return c[31:0];
            end
        endcase
    endfunction

    function automatic logic exp_dp(input int idx);
`ifdef PERF_MON_DP_EN
        return !((idx == 0 && m_mode == M_HALT) || (idx == 1 && m_mode == M_IDLE));
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_mode  = M_IDLE;
        n_edges = 0;
    endtask

    // advance the model from the inputs now applied, then cross one rising edge
    task automatic tick();
        logic [4:0] ev;
        exp_val_a = model_sel(sel, 1'b0);
        exp_val_b = model_sel(sel, 1'b1);
        ev = {bubble, branched, is_branch, jumped, 1'b1};
        if (clr) begin
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            m_mode = M_IDLE;
        end else begin
            if (en && !halted && m_mode != M_HALT)
                for (int i = 0; i < 5; i++) m_cnt[i] += ev[i];
            if (m_mode == M_IDLE && en) m_mode = M_RUN;
            else if (m_mode == M_RUN && en && halted) m_mode = M_HALT;
        end
        @(posedge clk);
        #1;
        n_edges++;
    endtask

    task automatic check_scan();
        int ia, ib;
        ia = (n_edges / 4) % 8;
        ib = (n_edges / 2) % 8;
        check("an_n_a", {24'h0, an_n_a}, {24'h0, ~(8'd1 << ia)});
        check("an_n_b", {24'h0, an_n_b}, {24'h0, ~(8'd1 << ib)});
        check("dp_a", {31'h0, seg_n_a[7]}, {31'h0, exp_dp(ia)});
        check("dp_b", {31'h0, seg_n_b[7]}, {31'h0, exp_dp(ib)});
    endtask

    task automatic set_in(input vec_t v);
        clr = v.clr; en = v.en; halted = v.halted; jumped = v.jumped;
        is_branch = v.is_branch; branched = v.branched; bubble = v.bubble; sel = v.sel;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value_a"}, value_a, 32'h0);
        check({tag, "_value_b"}, value_b, 32'h0);
        check({tag, "_state_a"}, {30'h0, state_a}, 32'h0);
        check({tag, "_state_b"}, {30'h0, state_b}, 32'h0);
        check({tag, "_an_n_a"}, {24'h0, an_n_a}, 32'hFE);
        check({tag, "_an_n_b"}, {24'h0, an_n_b}, 32'hFE);
        check({tag, "_seg_n_a"}, {24'h0, seg_n_a}, 32'hC0);
        check({tag, "_seg_n_b"}, {24'h0, seg_n_b}, 32'hC0);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        {clr, en, halted, jumped, is_branch, branched, bubble} = '0;
        sel     = 3'd7;
        display = 32'h1234ABCD;
        pc_dbg  = 32'hCAFE0040;
        digit_seg = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
        model_reset();

        // clr en hlt jmp isb brt bub sel reps state value_a value_b
        vq.push_back('{0,1,0,0,0,0,0,3'd1, 2,2'd1,32'd1,32'd1});
        vq.push_back('{0,1,0,1,0,0,0,3'd1, 2,2'd1,32'd3,32'd3});
        vq.push_back('{0,1,0,0,0,0,0,3'd1, 1,2'd1,32'd4,32'd4});
        vq.push_back('{0,1,0,0,1,1,0,3'd1, 1,2'd1,32'd5,32'd5});
        vq.push_back('{0,1,0,0,0,0,0,3'd1, 4,2'd1,32'd9,32'd9});
        vq.push_back('{0,1,1,0,0,0,0,3'd1, 1,2'd2,32'd10,32'd10});
        vq.push_back('{0,1,1,0,0,0,0,3'd2, 1,2'd2,32'd2,32'd2});
        vq.push_back('{0,1,1,0,0,0,0,3'd4, 1,2'd2,32'd1,32'd1});
        vq.push_back('{0,1,1,0,0,0,0,3'd3, 1,2'd2,32'd1,32'd1});
        vq.push_back('{0,1,0,1,0,0,1,3'd1, 3,2'd2,32'd10,32'd10});
        vq.push_back('{0,1,0,1,0,0,0,3'd2, 1,2'd2,32'd2,32'd2});
        vq.push_back('{0,1,0,0,0,0,1,3'd5, 1,2'd2,32'd0,32'd0});
        vq.push_back('{1,1,0,0,0,0,0,3'd1, 1,2'd0,32'd10,32'd10});
        vq.push_back('{0,1,0,0,0,0,0,3'd1, 1,2'd1,32'd0,32'd0});
        vq.push_back('{0,0,0,0,0,0,0,3'd1, 1,2'd1,32'd1,32'd1});
        vq.push_back('{0,1,0,0,0,0,1,3'd1,20,2'd1,32'd20,32'd15});
        vq.push_back('{0,0,0,0,0,0,0,3'd5, 1,2'd1,32'd20,32'd15});
        vq.push_back('{0,0,0,0,0,0,0,3'd1, 1,2'd1,32'd21,32'd15});
        vq.push_back('{0,0,0,0,0,0,0,3'd0, 1,2'd1,32'h1234ABCD,32'h1234ABCD});
        vq.push_back('{0,0,0,0,0,0,0,3'd6, 1,2'd1,32'hCAFE0040,32'hCAFE0040});
        vq.push_back('{0,0,0,0,0,0,0,3'd7, 1,2'd1,32'd0,32'd0});
        vq.push_back('{1,0,0,0,0,0,0,3'd1, 1,2'd0,32'd21,32'd15});
        vq.push_back('{0,1,1,0,0,0,0,3'd1, 1,2'd1,32'd0,32'd0});
        vq.push_back('{0,1,1,0,0,0,0,3'd1, 1,2'd2,32'd0,32'd0});
        vq.push_back('{0,1,0,0,0,0,0,3'd1, 1,2'd2,32'd0,32'd0});

        // reset values, then release between edges so the next edge is edge 1
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;

        // scan walk with value held at zero
        for (int k = 0; k < 40; k++) begin
            tick();
            check_scan();
            check("scan0_seg_a", {25'h0, seg_n_a[6:0]}, 32'h40);
            check("scan0_seg_b", {25'h0, seg_n_b[6:0]}, 32'h40);
        end

        // directed vector table
        foreach (vq[r]) begin
            v = vq[r];
            set_in(v);
            for (int k = 0; k < v.reps; k++) tick();
            check($sformatf("vec%0d_state_a", r), {30'h0, state_a}, {30'h0, v.st});
            check($sformatf("vec%0d_state_b", r), {30'h0, state_b}, {30'h0, v.st});
            check($sformatf("vec%0d_value_a", r), value_a, v.va);
            check($sformatf("vec%0d_value_b", r), value_b, v.vb);
            check_scan();
        end

        // display scan: value = 32'h1234ABCD held long enough to cover a full digit sweep
        {clr, en, halted, jumped, is_branch, branched, bubble} = '0;
        sel = 3'd0;
        for (int k = 0; k < 20; k++) tick();
        for (int k = 0; k < 32; k++) begin
            tick();
            check_scan();
            check("digit_seg_a", {25'h0, seg_n_a[6:0]}, {25'h0, digit_seg[(n_edges / 4) % 8]});
            check("digit_seg_b", {25'h0, seg_n_b[6:0]}, {25'h0, digit_seg[(n_edges / 2) % 8]});
        end

        // random stimulus against the model
        clr = 1'b1;
        tick();
        for (int k = 0; k < 400; k++) begin
            clr       = ($urandom_range(0, 39) == 0);
            en        = ($urandom_range(0, 3) != 0);
            halted    = ($urandom_range(0, 11) == 0);
            jumped    = $urandom_range(0, 1);
            is_branch = $urandom_range(0, 1);
            branched  = $urandom_range(0, 1);
            bubble    = $urandom_range(0, 1);
            sel       = 3'($urandom_range(0, 7));
            display   = $urandom;
            pc_dbg    = $urandom;
            tick();
            check("rnd_value_a", value_a, exp_val_a);
            check("rnd_value_b", value_b, exp_val_b);
            check("rnd_state_a", {30'h0, state_a}, m_mode);
            check("rnd_state_b", {30'h0, state_b}, m_mode);
            check_scan();
        end

        // asynchronous reset in the middle of a scan slot
        {clr, en, halted, jumped, is_branch, branched, bubble} = '0;
        sel = 3'd7;
        for (int k = 0; k < 5; k++) tick();
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        #1 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_scan();
            check("post_reset_seg_a", {25'h0, seg_n_a[6:0]}, 32'h40);
            check("post_reset_seg_b", {25'h0, seg_n_b[6:0]}, 32'h40);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
